dqs_delay_cal: RTL and testbench

Calibration sequencer for the read-DQS tap delay line. On request it sweeps the 3-bit tap select across all 8 settings. At each setting it runs one or more test reads through the controller read path and records pass/fail per tap. It then programs the centre of the longest passing window. Sits between the controller's init/training FSM and the select input of the DQS delay buffer.

---
 rtl/dqs_delay_cal.sv | 206 ++++++++++++++++++++
 tb/tb_dqs_delay_cal.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqs_delay_cal.sv
// Read-DQS tap calibration: sweeps the 3-bit delay select, runs test reads at each
// tap, then programs the centre of the longest passing window.
module dqs_delay_cal #(
  parameter int SETTLE_CYCLES = 4,
  parameter int READS_PER_TAP = 2,
  parameter int ACK_TIMEOUT   = 64,
  parameter int DEFAULT_TAP   = 3
) (
  input  logic       ref_clk,
  input  logic       rst,
  input  logic       cal_start,
  input  logic       man_en,
  input  logic [2:0] man_tap,
  output logic       tst_req,
  input  logic       tst_ack,
  input  logic       tst_pass,
  output logic [2:0] dly_sel,
  output logic       busy,
  output logic       done,
  output logic       cal_ok,
  output logic [7:0] pass_map
);

  localparam logic [2:0] DEF_TAP     = 3'(DEFAULT_TAP);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] READS_LAST  = 4'(READS_PER_TAP - 1);
  localparam logic [9:0] TO_LAST     = 10'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_APPLY  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0] r_state;
  logic [2:0] r_tap;
  logic [7:0] r_settle_cnt;
  logic [9:0] r_to_cnt;
  logic [3:0] r_rd_cnt;
  logic       r_tap_fail;
  logic [2:0] r_eval_idx;
  logic [2:0] r_run_start;
  logic [3:0] r_run_len;
  logic [2:0] r_best_start;
  logic [3:0] r_best_len;

  logic       r_tst_req;
  logic [2:0] r_dly_sel;
  logic       r_busy;
  logic       r_done;
  logic       r_cal_ok;
  logic [7:0] r_pass_map;

  logic       w_timeout;
  logic       w_read_fail;
  logic       w_last_read;
  logic       w_bit;
  logic [2:0] w_new_start;
  logic [3:0] w_new_len;

  // An ack in the timeout cycle still counts: the fail decision looks only at the ack.
  assign w_timeout   = (r_to_cnt == TO_LAST);
  assign w_read_fail = !(tst_ack && tst_pass);
  assign w_last_read = (r_rd_cnt == READS_LAST);
  assign w_bit       = r_pass_map[r_eval_idx];
  assign w_new_start = (r_run_len == 4'd0) ? r_eval_idx : r_run_start;
  assign w_new_len   = r_run_len + 4'd1;

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values and the order of statements inside the block cannot matter.
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tap        <= 3'd0;
      r_settle_cnt <= 8'd0;
      r_to_cnt     <= 10'd0;
      r_rd_cnt     <= 4'd0;
      r_tap_fail   <= 1'b0;
      r_eval_idx   <= 3'd0;
      r_run_start  <= 3'd0;
      r_run_len    <= 4'd0;
      r_best_start <= 3'd0;
      r_best_len   <= 4'd0;
      r_tst_req    <= 1'b0;
      r_dly_sel    <= DEF_TAP;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cal_ok     <= 1'b0;
      r_pass_map   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cal_start && !man_en) begin
            r_state      <= S_SETTLE;
            r_tap        <= 3'd0;
            r_dly_sel    <= 3'd0;
            r_pass_map   <= 8'd0;
            r_cal_ok     <= 1'b0;
            r_busy       <= 1'b1;
            r_settle_cnt <= 8'd0;
            r_rd_cnt     <= 4'd0;
          end else if (man_en) begin
            r_dly_sel <= man_tap;
          end
        end

        S_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_REQ;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end

        S_REQ: begin
          r_tst_req <= 1'b1;
          r_to_cnt  <= 10'd0;
          r_state   <= S_WAIT;
        end

        S_WAIT: begin
          if (tst_ack || w_timeout) begin
            r_tst_req <= 1'b0;
            r_rd_cnt  <= r_rd_cnt + 4'd1;
            if (!w_read_fail && !w_last_read) begin
              r_state <= S_REQ;
            end else begin
              r_tap_fail <= w_read_fail;
              r_state    <= S_NEXT;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 10'd1;
          end
        end

        S_NEXT: begin
          r_pass_map[r_tap] <= !r_tap_fail;
          if (r_tap == 3'd7) begin
            r_eval_idx   <= 3'd0;
            r_run_start  <= 3'd0;
            r_run_len    <= 4'd0;
            r_best_start <= 3'd0;
            r_best_len   <= 4'd0;
            r_state      <= S_EVAL;
          end else begin
            r_tap        <= r_tap + 3'd1;
            r_dly_sel    <= r_tap + 3'd1;
            r_settle_cnt <= 8'd0;
            r_rd_cnt     <= 4'd0;
            r_state      <= S_SETTLE;
          end
        end

        S_EVAL: begin
          // Strictly-longer replacement keeps the lowest-index run on a tie.
          if (w_bit) begin
            r_run_start <= w_new_start;
            r_run_len   <= w_new_len;
            if (w_new_len > r_best_len) begin
              r_best_start <= w_new_start;
              r_best_len   <= w_new_len;
            end
          end else begin
            r_run_len <= 4'd0;
          end
          if (r_eval_idx == 3'd7) begin
            r_state <= S_APPLY;
          end else begin
            r_eval_idx <= r_eval_idx + 3'd1;
          end
        end

        S_APPLY: begin
          if (r_best_len != 4'd0) begin
            r_dly_sel <= 3'(r_best_start + ((r_best_len - 4'd1) >> 1));
            r_cal_ok  <= 1'b1;
          end else begin
            r_dly_sel <= DEF_TAP;
            r_cal_ok  <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tst_req  = r_tst_req;
  assign dly_sel  = r_dly_sel;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cal_ok   = r_cal_ok;
  assign pass_map = r_pass_map;

endmodule

// File: tb/tb_dqs_delay_cal.sv
// Directed bench for dqs_delay_cal: a read-path responder plus a scoreboard of
// expected calibration results popped when done pulses.
module tb_dqs_delay_cal;

  localparam int         SETTLE  = 4;
  localparam int         READS   = 2;
  localparam int         TIMEOUT = 64;
  localparam int         DEF     = 3;
  localparam int         BUDGET  = 5000;

  typedef struct packed {
    logic [7:0] map;
    logic [2:0] sel;
    logic       ok;
  } exp_t;

  logic       ref_clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       man_en;
  logic [2:0] man_tap;
  logic       tst_req;
  logic       tst_ack;
  logic       tst_pass;
  logic [2:0] dly_sel;
  logic       busy;
  logic       done;
  logic       cal_ok;
  logic [7:0] pass_map;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  logic [7:0] cfg_pass = 8'h00;
  int cfg_fail_tap  = -1;
  int cfg_fail_read = 0;
  int cfg_noack_tap = -1;
  int cfg_late_tap  = -1;
  int req_pulses[8];
  int req_high[8];

  always #5 ref_clk = ~ref_clk;

  dqs_delay_cal #(
    .SETTLE_CYCLES(SETTLE),
    .READS_PER_TAP(READS),
    .ACK_TIMEOUT  (TIMEOUT),
    .DEFAULT_TAP  (DEF)
  ) dut (
    .ref_clk  (ref_clk),
    .rst      (rst),
    .cal_start(cal_start),
    .man_en   (man_en),
    .man_tap  (man_tap),
    .tst_req  (tst_req),
    .tst_ack  (tst_ack),
    .tst_pass (tst_pass),
    .dly_sel  (dly_sel),
    .busy     (busy),
    .done     (done),
    .cal_ok   (cal_ok),
    .pass_map (pass_map)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: brute-force longest run from every start index.
  function automatic exp_t model(input logic [7:0] m);
    int best_len, best_s, len;
    exp_t e;
    best_len = 0;
    best_s   = 0;
    for (int s = 0; s < 8; s++) begin
      len = 0;
      while (s + len < 8 && m[s + len]) len++;
      if (len > best_len) begin
        best_len = len;
        best_s   = s;
      end
    end
    e.map = m;
    e.ok  = (best_len > 0);
    e.sel = (best_len > 0) ? 3'(best_s + (best_len - 1) / 2) : 3'(DEF);
    return e;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) begin
      req_pulses[i] = 0;
      req_high[i]   = 0;
    end
  endtask

  // Read-path responder: acks in the first tst_req cycle unless configured otherwise.
  initial begin
    logic prev_req;
    int   req_cyc;
    int   rd;
    int   tap;
    prev_req = 1'b0;
    req_cyc  = 0;
    tst_ack  = 1'b0;
    tst_pass = 1'b0;
    forever begin
      @(negedge ref_clk);
      tst_ack  = 1'b0;
      tst_pass = 1'b0;
      if (tst_req === 1'b1) begin
        tap = int'(dly_sel);
        if (!prev_req) begin
          req_pulses[tap]++;
          req_cyc = 0;
        end
        req_cyc++;
        req_high[tap]++;
        rd = req_pulses[tap] - 1;
        if (tap != cfg_noack_tap && req_cyc == ((tap == cfg_late_tap) ? TIMEOUT : 1)) begin
          tst_ack  = 1'b1;
          tst_pass = cfg_pass[tap] && !(tap == cfg_fail_tap && rd == cfg_fail_read);
        end
      end
      prev_req = (tst_req === 1'b1);
    end
  end

  task automatic run_cal(input exp_t e, input int restart_at, output int lat);
    exp_t got;
    clear_counts();
    sb.push_back(e);
    cal_start = 1'b1;
    @(negedge ref_clk);
    cal_start = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1);
    while (!done && lat < BUDGET) begin
      @(negedge ref_clk);
      lat++;
      cal_start = (restart_at > 0 && lat == restart_at);
      man_en    = (restart_at > 0 && lat >= restart_at && lat < restart_at + 10);
      man_tap   = 3'd6;
    end
    cal_start = 1'b0;
    man_en    = 1'b0;
    check("done_seen", done, 1);
    if (done) begin
      got = sb.pop_front();
      check("pass_map", pass_map, got.map);
      check("dly_sel",  dly_sel,  got.sel);
      check("cal_ok",   cal_ok,   got.ok);
      check("busy_at_done", busy, 0);
      @(negedge ref_clk);
      check("done_one_cycle", done, 0);
      check("sel_hold_after_done", dly_sel, got.sel);
    end
  endtask

  initial begin
    int   lat;
    int   cyc;
    int   done_seen;
    logic [7:0] m;

    rst       = 1'b1;
    cal_start = 1'b0;
    man_en    = 1'b0;
    man_tap   = 3'd0;
    repeat (3) @(negedge ref_clk);
    rst = 1'b0;
    @(negedge ref_clk);
    check("rst_dly_sel",  dly_sel,  DEF);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_tst_req",  tst_req,  0);
    check("rst_pass_map", pass_map, 0);
    check("rst_cal_ok",   cal_ok,   0);

    man_en  = 1'b1;
    man_tap = 3'd6;
    @(negedge ref_clk);
    check("man_follow_6", dly_sel, 6);
    cal_start = 1'b1;
    @(negedge ref_clk);
    cal_start = 1'b0;
    check("man_blocks_start", busy, 0);
    man_tap = 3'd2;
    @(negedge ref_clk);
    check("man_follow_2", dly_sel, 2);
    man_en  = 1'b0;
    man_tap = 3'd5;
    @(negedge ref_clk);
    check("man_off_hold", dly_sel, 2);

    cfg_pass = 8'h3C;
    run_cal('{map: 8'h3C, sel: 3'd3, ok: 1'b1}, 0, lat);

    cfg_pass = 8'h73;
    run_cal('{map: 8'h73, sel: 3'd5, ok: 1'b1}, 0, lat);

    cfg_pass = 8'h66;
    run_cal('{map: 8'h66, sel: 3'd1, ok: 1'b1}, 0, lat);

    cfg_pass = 8'h00;
    run_cal('{map: 8'h00, sel: 3'(DEF), ok: 1'b0}, 0, lat);
    check("allfail_req_tap0", req_pulses[0], 1);
    check("allfail_req_tap7", req_pulses[7], 1);

    cfg_pass      = 8'hFF;
    cfg_fail_tap  = 4;
    cfg_fail_read = 1;
    run_cal('{map: 8'hEF, sel: 3'd1, ok: 1'b1}, 0, lat);
    check("tap4_req_pulses", req_pulses[4], 2);
    cfg_fail_tap = -1;

    cfg_noack_tap = 7;
    cfg_late_tap  = 2;
    run_cal('{map: 8'h7F, sel: 3'd3, ok: 1'b1}, 0, lat);
    check("tap7_req_high", req_high[7], TIMEOUT);
    check("tap7_req_pulses", req_pulses[7], 1);
    check("tap2_late_req_high", req_high[2], 2 * TIMEOUT);
    cfg_noack_tap = -1;
    cfg_late_tap  = -1;

    cfg_pass = 8'hFF;
    run_cal('{map: 8'hFF, sel: 3'd3, ok: 1'b1}, 20, lat);
    check("latency_all_pass", lat, 8 * (SETTLE + 2 * READS + 1) + 8 + 2);

    for (int i = 0; i < 2; i++) begin
      m = 8'($urandom_range(0, 255));
      cfg_pass = m;
      run_cal(model(m), 0, lat);
    end

    cfg_pass = 8'hFF;
    clear_counts();
    cal_start = 1'b1;
    @(negedge ref_clk);
    cal_start = 1'b0;
    cyc = 0;
    while (!(dly_sel == 3'd5 && tst_req === 1'b1) && cyc < BUDGET) begin
      @(negedge ref_clk);
      cyc++;
    end
    check("reach_tap5_wait", (dly_sel == 3'd5 && tst_req === 1'b1), 1);
    rst = 1'b1;
    @(negedge ref_clk);
    rst = 1'b0;
    check("midrst_tst_req",  tst_req,  0);
    check("midrst_busy",     busy,     0);
    check("midrst_dly_sel",  dly_sel,  DEF);
    check("midrst_pass_map", pass_map, 0);
    done_seen = 0;
    repeat (120) begin
      @(negedge ref_clk);
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_idle_busy", busy, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
